// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch (IF) and the
// load/store unit (LSU); one outstanding transaction, LSU priority with starvation bound.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner_if;
  logic [CNT_W-1:0]  starve_cnt;
  logic              lat_we;
  logic [BE_W-1:0]   lat_be;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              any_req;
  logic              if_win;
  logic              arb_edge;
  logic              resp_vld;

  // IF only beats a waiting LSU once it has lost STARVE_LIMIT arbitrations in a row.
  always_comb begin
    any_req  = if_req | ls_req;
    if_win   = if_req & (~ls_req | (starve_cnt == CNT_MAX));
    arb_edge = (state == IDLE) & any_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)    state_nxt = REQ;
      REQ:     if (mem_gnt)    state_nxt = RESP;
      RESP:    if (mem_rvalid) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_if  <= 1'b0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (arb_edge) begin
      owner_if <= if_win;
      if (if_win) begin
        lat_we    <= 1'b0;
        lat_be    <= '1;
        lat_addr  <= if_addr;
        lat_wdata <= '0;
      end else begin
        lat_we    <= ls_we;
        lat_be    <= ls_be;
        lat_addr  <= ls_addr;
        lat_wdata <= ls_wdata;
      end
    end
  end

  // Counter only moves on arbitration edges; it is frozen while a transaction is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (arb_edge) begin
      if (if_win || !if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mem_req   = (state == REQ);
    busy      = (state != IDLE);
    resp_vld  = (state == RESP) & mem_rvalid;
    if_gnt    = mem_req & mem_gnt & owner_if;
    ls_gnt    = mem_req & mem_gnt & ~owner_if;
    if_rvalid = resp_vld & owner_if;
    ls_rvalid = resp_vld & ~owner_if;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
    mem_we    = lat_we;
    mem_be    = lat_be;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus contention and reset sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct packed {
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, busy;
    logic [31:0] if_rdata, ls_rdata;
  } ctl_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
  } memf_t;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req, ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    ctl_t        exp;
    memf_t       exp_mem;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t ctl(input logic ig, irv, lg, lrv, mr, bz, input logic [31:0] ird, lrd);
    return {ig, irv, lg, lrv, mr, bz, ird, lrd};
  endfunction

  function automatic memf_t mf(input logic we, input logic [3:0] be, input logic [31:0] addr, wd);
    return {we, be, addr, wd};
  endfunction

  task automatic add(input logic ireq, input logic [31:0] iaddr, input logic lreq, lwe,
                     input logic [3:0] lbe, input logic [31:0] laddr, lwd,
                     input logic mg, mrv, input logic [31:0] mrd, input ctl_t e, input memf_t m);
    vec_t v;
    v.if_req = ireq; v.if_addr = iaddr; v.ls_req = lreq; v.ls_we = lwe; v.ls_be = lbe;
    v.ls_addr = laddr; v.ls_wdata = lwd; v.mem_gnt = mg; v.mem_rvalid = mrv; v.mem_rdata = mrd;
    v.exp = e; v.exp_mem = m;
    tbl.push_back(v);
  endtask

  task automatic cmp_ctl(input string name, input ctl_t e);
    ctl_t a;
    a = {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, busy, if_rdata, ls_rdata};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s ctl: got %h expected %h (gnt/rvalid/req/busy/rdata)", name, a, e);
    end
  endtask

  task automatic cmp_mem(input string name, input memf_t e);
    memf_t a;
    a = {mem_we, mem_be, mem_addr, mem_wdata};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s mem: got %h expected %h (we/be/addr/wdata)", name, a, e);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  // A requester must keep req asserted until it sees its gnt.
  logic if_pend, ls_pend;
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      if_pend <= 1'b0;
      ls_pend <= 1'b0;
    end else begin
      assert (!(if_pend && !if_req)) else $error("protocol: if_req dropped before if_gnt");
      assert (!(ls_pend && !ls_req)) else $error("protocol: ls_req dropped before ls_gnt");
      if_pend <= if_req && !if_gnt;
      ls_pend <= ls_req && !ls_gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_if;
    memf_t M0;
    ctl_t  C0;
    M0 = '0;
    C0 = '0;

    // Single IF read
    add(1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, C0, M0);
    add(1, 32'h20, 0, 0, 0, 0, 0, 1, 0, 0, ctl(1,0,0,0,1,1,0,0), mf(0, 4'hF, 32'h20, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093, ctl(0,1,0,0,0,1,32'h00500093,0), M0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, M0);
    // LSU write with three stall cycles
    add(0, 0, 1, 1, 4'h3, 32'h100, 32'hDEADBEEF, 0, 0, 0, C0, M0);
    for (int k = 0; k < 3; k++)
      add(0, 0, 1, 1, 4'h3, 32'h100, 32'hDEADBEEF, 0, 0, 0, ctl(0,0,0,0,1,1,0,0), mf(1, 4'h3, 32'h100, 32'hDEADBEEF));
    add(0, 0, 1, 1, 4'h3, 32'h100, 32'hDEADBEEF, 1, 0, 0, ctl(0,0,1,0,1,1,0,0), mf(1, 4'h3, 32'h100, 32'hDEADBEEF));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl(0,0,0,0,0,1,0,0), M0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, ctl(0,0,0,1,0,1,0,32'h12345678), M0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, M0);
    // Spurious mem_rvalid in IDLE/REQ and mem_gnt in RESP
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA, C0, M0);
    add(0, 0, 1, 0, 4'hF, 32'h40, 0, 0, 1, 32'hAAAA, C0, M0);
    add(0, 0, 1, 0, 4'hF, 32'h40, 0, 1, 1, 32'hAAAA, ctl(0,0,1,0,1,1,0,0), mf(0, 4'hF, 32'h40, 0));
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ctl(0,0,0,0,0,1,0,0), M0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ctl(0,0,0,0,0,1,0,0), M0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, ctl(0,0,0,1,0,1,0,32'h55), M0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, M0);
    // Back-to-back IF reads, zero-wait memory
    add(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, C0, M0);
    add(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, ctl(1,0,0,0,1,1,0,0), mf(0, 4'hF, 32'h0, 0));
    add(1, 32'h4, 0, 0, 0, 0, 0, 0, 1, 32'h11, ctl(0,1,0,0,0,1,32'h11,0), M0);
    add(1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, C0, M0);
    add(1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0, ctl(1,0,0,0,1,1,0,0), mf(0, 4'hF, 32'h4, 0));
    add(1, 32'h8, 0, 0, 0, 0, 0, 0, 1, 32'h22, ctl(0,1,0,0,0,1,32'h22,0), M0);
    add(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, C0, M0);
    add(1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0, ctl(1,0,0,0,1,1,0,0), mf(0, 4'hF, 32'h8, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33, ctl(0,1,0,0,0,1,32'h33,0), M0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, M0);

    // Reset state
    rst = 1'b0;
    idle_inputs();
    mem_rvalid = 1'b1;
    #3;
    cmp_ctl("reset", C0);
    cmp_mem("reset", M0);
    #9;
    mem_rvalid = 1'b0;
    rst = 1'b1;

    foreach (tbl[i]) begin
      step();
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      ls_req = tbl[i].ls_req; ls_we = tbl[i].ls_we; ls_be = tbl[i].ls_be;
      ls_addr = tbl[i].ls_addr; ls_wdata = tbl[i].ls_wdata;
      mem_gnt = tbl[i].mem_gnt; mem_rvalid = tbl[i].mem_rvalid; mem_rdata = tbl[i].mem_rdata;
      @(negedge clk);
      cmp_ctl($sformatf("vec%0d", i), tbl[i].exp);
      if (tbl[i].exp.mem_req) cmp_mem($sformatf("vec%0d", i), tbl[i].exp_mem);
    end

    // Contention: both held; expected order L,L,L,L,IF,L,L,L,L,IF then a lone LSU
    step();
    idle_inputs();
    if_req = 1; if_addr = 32'h300; ls_req = 1; ls_be = 4'hF; ls_addr = 32'h200;
    for (int t = 0; t < 11; t++) begin
      exp_if = (t == 4 || t == 9);
      @(negedge clk);
      check_val($sformatf("cont%0d_idle_busy", t), {31'd0, busy}, 32'd0);
      step();
      mem_gnt = 1;
      @(negedge clk);
      check_val($sformatf("cont%0d_gnt", t), {30'd0, if_gnt, ls_gnt}, {30'd0, exp_if, !exp_if});
      check_val($sformatf("cont%0d_addr", t), mem_addr, exp_if ? 32'h300 : 32'h200);
      step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'(t) + 32'hC00;
      if (t == 9) if_req = 0;
      if (t == 10) ls_req = 0;
      @(negedge clk);
      check_val($sformatf("cont%0d_rvalid", t), {30'd0, if_rvalid, ls_rvalid}, {30'd0, exp_if, !exp_if});
      check_val($sformatf("cont%0d_rdata", t), exp_if ? if_rdata : ls_rdata, 32'(t) + 32'hC00);
      step();
      mem_rvalid = 0; mem_rdata = 0;
    end

    // Reset asserted mid-RESP, then a late mem_rvalid
    @(negedge clk);
    step();
    ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h80;
    @(negedge clk);
    check_val("rst_seq_idle_busy", {31'd0, busy}, 32'd0);
    step();
    mem_gnt = 1;
    @(negedge clk);
    check_val("rst_seq_gnt", {31'd0, ls_gnt}, 32'd1);
    step();
    ls_req = 0; mem_gnt = 0;
    @(negedge clk);
    check_val("rst_seq_resp_busy", {31'd0, busy}, 32'd1);
    check_val("rst_seq_resp_addr", mem_addr, 32'h80);
    #1;
    rst = 1'b0;
    mem_rvalid = 1; mem_rdata = 32'h99;
    #1;
    cmp_ctl("rst_async", C0);
    cmp_mem("rst_async", M0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    step();
    @(negedge clk);
    cmp_ctl("late_rvalid", C0);
    step();
    mem_rvalid = 0; mem_rdata = 0;
    @(negedge clk);
    cmp_ctl("post_rst_idle", C0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
